// File: rtl/matmul_cfg_queue.sv
// Configuration front-end for the systolic matmul engine: reassembles bus beats into
// data_config_struct records, validates them and queues accepted ones in a FIFO.
// Ports: clk/rst_n/flush; cfg_in_* beat stream (valid/ready, last); cfg_out_* FIFO head
// (valid/ready), cfg_count occupancy; err_valid/err_code/err_count rejection reporting.
// Latency: last beat in cycle N, record visible at the head in N+2 when the FIFO is empty.
// A full FIFO holds the record in COMMIT, which drops cfg_in_ready until a slot frees.
module matmul_cfg_queue #(
  parameter int MAX_ROW    = 16,
  parameter int MAX_COL    = 16,
  parameter int W_SIZE     = 512,
  parameter int I_SIZE     = 512,
  parameter int O_SIZE     = 512,
  parameter int EXTRA_BITS = 4,
  parameter int BUS_W      = 16,
  parameter int DEPTH      = 4,
  localparam int RW    = $clog2(MAX_ROW),
  localparam int CW    = $clog2(MAX_COL),
  localparam int WW    = $clog2(W_SIZE),
  localparam int IW    = $clog2(I_SIZE),
  localparam int OW    = $clog2(O_SIZE),
  localparam int CFG_W = RW + CW + IW + WW + IW + 2 * OW + 1 + EXTRA_BITS,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cfg_in_valid,
  output logic             cfg_in_ready,
  input  logic [BUS_W-1:0] cfg_in_data,
  input  logic             cfg_in_last,
  output logic             cfg_out_valid,
  input  logic             cfg_out_ready,
  output logic [CFG_W-1:0] cfg_out,
  output logic [PW:0]      cfg_count,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [7:0]       err_count
);

  localparam int NBEATS = (CFG_W + BUS_W - 1) / BUS_W;
  localparam int BCW    = $clog2(NBEATS + 1);

  typedef struct packed {
    logic [RW-1:0]         w_rows;
    logic [CW-1:0]         w_cols;
    logic [IW-1:0]         i_rows;
    logic [WW-1:0]         w_offset;
    logic [IW-1:0]         i_offset;
    logic [OW-1:0]         psum_offset;
    logic [OW-1:0]         o_offset_w;
    logic                  accum_en;
    logic [EXTRA_BITS-1:0] extra_config;
  } data_config_struct;

  typedef enum logic [1:0] {ASSEMBLE, COMMIT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [BCW-1:0]    beat_cnt;
  logic [CFG_W-1:0]  asm_q, asm_nxt;
  data_config_struct rec;
  data_config_struct mem [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              full, pop, push, last_beat;
  logic              beat_acc, cnt_clr, cnt_inc, frame_err, chk_err;
  logic [1:0]        chk_code;
  logic              zero_dim, range_bad;
  logic [31:0]       w_end, i_end, o_end, p_end;

  assign rec       = asm_q;
  assign last_beat = (beat_cnt == BCW'(NBEATS - 1));

  // FIFO status; the extra pointer bit separates full from empty
  assign cfg_count     = wr_ptr - rd_ptr;
  assign cfg_out_valid = (wr_ptr != rd_ptr);
  assign full          = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cfg_out       = mem[rd_ptr[PW-1:0]];
  assign pop           = cfg_out_valid && cfg_out_ready;

  // End addresses in 32 bits so the bound comparison never wraps
  assign w_end     = 32'(rec.w_offset) + 32'(rec.w_rows);
  assign i_end     = 32'(rec.i_offset) + 32'(rec.i_rows);
  assign o_end     = 32'(rec.o_offset_w) + 32'(rec.i_rows);
  assign p_end     = 32'(rec.psum_offset) + 32'(rec.i_rows);
  assign zero_dim  = (rec.w_rows == '0) || (rec.w_cols == '0) || (rec.i_rows == '0);
  assign range_bad = (w_end > 32'(W_SIZE)) || (i_end > 32'(I_SIZE)) || (o_end > 32'(O_SIZE)) ||
                     (rec.accum_en && (p_end > 32'(O_SIZE)));

  // Beat k lands LSB-first at bits [k*BUS_W +: BUS_W]; bits past CFG_W are dropped
  always_comb begin
    asm_nxt = asm_q;
    for (int b = 0; b < CFG_W; b++) begin
      if (beat_acc && (int'(beat_cnt) == b / BUS_W)) asm_nxt[b] = cfg_in_data[b % BUS_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ASSEMBLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cfg_in_ready = 1'b0;
    beat_acc     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    frame_err    = 1'b0;
    chk_err      = 1'b0;
    chk_code     = 2'b00;
    push         = 1'b0;
    case (state)
      ASSEMBLE: begin
        cfg_in_ready = 1'b1;
        if (cfg_in_valid) begin
          beat_acc = 1'b1;
          if (last_beat) begin
            cnt_clr = 1'b1;
            if (cfg_in_last) begin
              state_nxt = COMMIT;
            end else begin
              // record overran its length: skip to the next 'last'
              frame_err = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (cfg_in_last) begin
            cnt_clr   = 1'b1;
            frame_err = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        cfg_in_ready = 1'b1;
        if (cfg_in_valid && cfg_in_last) state_nxt = ASSEMBLE;
      end
      COMMIT: begin
        if (zero_dim) begin
          chk_err   = 1'b1;
          chk_code  = 2'b10;
          state_nxt = ASSEMBLE;
        end else if (range_bad) begin
          chk_err   = 1'b1;
          chk_code  = 2'b11;
          state_nxt = ASSEMBLE;
        end else if (!full || pop) begin
          push      = 1'b1;
          state_nxt = ASSEMBLE;
        end
      end
      default: state_nxt = ASSEMBLE;
    endcase
    // flush discards any in-flight beat or pending record without reporting it
    if (flush) begin
      state_nxt = ASSEMBLE;
      beat_acc  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b1;
      frame_err = 1'b0;
      chk_err   = 1'b0;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      asm_q    <= '0;
    end else begin
      asm_q <= asm_nxt;
      if (cnt_clr)      beat_cnt <= '0;
      else if (cnt_inc) beat_cnt <= beat_cnt + BCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= rec;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      err_count <= 8'd0;
    end else begin
      err_valid <= frame_err || chk_err;
      if (frame_err || chk_err) begin
        err_code <= frame_err ? 2'b01 : chk_code;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_cfg_queue.sv
`timescale 1ns/1ps
module tb_matmul_cfg_queue;
  localparam int CFG_W = 58;
  localparam int BUS_W = 16;
  localparam int NB    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             cfg_in_valid = 1'b0;
  logic             cfg_in_ready;
  logic [BUS_W-1:0] cfg_in_data = '0;
  logic             cfg_in_last = 1'b0;
  logic             cfg_out_valid;
  logic             cfg_out_ready = 1'b0;
  logic [CFG_W-1:0] cfg_out;
  logic [2:0]       cfg_count;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [7:0]       err_count;

  matmul_cfg_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
    .cfg_in_data(cfg_in_data), .cfg_in_last(cfg_in_last),
    .cfg_out_valid(cfg_out_valid), .cfg_out_ready(cfg_out_ready),
    .cfg_out(cfg_out), .cfg_count(cfg_count),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr; int wc; int ir; int wo; int io; int po; int oo; int acc; int ex; int code;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [CFG_W-1:0] m_q[$];
  int m_errs = 0;
  int m_raw = 0;
  logic [1:0] m_code = 2'b00;
  int pulses = 0;

  always @(negedge clk) if (rst_n && err_valid) pulses++;

  initial begin
    #800000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CFG_W-1:0] pack(input vec_t v);
    return {4'(v.wr), 4'(v.wc), 9'(v.ir), 9'(v.wo), 9'(v.io), 9'(v.po), 9'(v.oo), 1'(v.acc), 4'(v.ex)};
  endfunction

  // Expected verdict from the acceptance rules: 0 accept, 2 zero dimension, 3 range
  function automatic int model_code(input vec_t v);
    if (v.wr == 0 || v.wc == 0 || v.ir == 0) return 2;
    if (v.wo + v.wr > 512 || v.io + v.ir > 512 || v.oo + v.ir > 512 ||
        (v.acc != 0 && v.po + v.ir > 512)) return 3;
    return 0;
  endfunction

  task automatic model_err(input logic [1:0] code);
    m_raw++;
    if (m_errs < 255) m_errs++;
    m_code = code;
  endtask

  task automatic model_apply(input vec_t v, input int code);
    if (code == 0) m_q.push_back(pack(v));
    else model_err(2'(code));
  endtask

  task automatic beat(input logic [BUS_W-1:0] d, input logic last);
    int n = 0;
    while (!cfg_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    cfg_in_valid = 1'b1;
    cfg_in_data  = d;
    cfg_in_last  = last;
    @(negedge clk);
    cfg_in_valid = 1'b0;
    cfg_in_last  = 1'b0;
  endtask

  task automatic send_rec(input vec_t v);
    logic [63:0] r;
    r = 64'(pack(v));
    for (int k = 0; k < NB; k++) begin
      beat(r[15:0], k == NB - 1);
      r = r >> 16;
    end
  endtask

  task automatic check_state(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, 64'(cfg_count), 64'(m_q.size()));
    chk({tag, "_err_count"}, 64'(err_count), 64'(m_errs));
    chk({tag, "_err_code"}, 64'(err_code), 64'(m_code));
    chk({tag, "_pulses"}, 64'(pulses), 64'(m_raw));
  endtask

  task automatic pop_one();
    chk("head_valid", 64'(cfg_out_valid), 64'(1));
    chk("head_data", 64'(cfg_out), 64'(m_q[0]));
    cfg_out_ready = 1'b1;
    @(negedge clk);
    cfg_out_ready = 1'b0;
    void'(m_q.pop_front());
  endtask

  initial begin
    vec_t tbl[12];
    vec_t v;
    vec_t v5;

    tbl[0]  = '{4, 4, 8, 0, 16, 0, 32, 0, 0, 0};
    tbl[1]  = '{4, 4, 20, 0, 500, 0, 0, 0, 0, 3};
    tbl[2]  = '{4, 0, 8, 0, 0, 0, 0, 0, 0, 2};
    tbl[3]  = '{4, 4, 4, 0, 0, 510, 0, 1, 0, 3};
    tbl[4]  = '{4, 4, 4, 0, 0, 510, 0, 0, 5, 0};
    tbl[5]  = '{15, 3, 2, 497, 7, 9, 11, 1, 10, 0};
    tbl[6]  = '{15, 3, 2, 498, 0, 0, 0, 0, 0, 3};
    tbl[7]  = '{1, 1, 8, 0, 0, 0, 504, 0, 15, 0};
    tbl[8]  = '{1, 1, 8, 0, 0, 0, 505, 0, 0, 3};
    tbl[9]  = '{0, 4, 8, 0, 511, 0, 0, 0, 0, 2};
    tbl[10] = '{2, 9, 1, 100, 511, 200, 300, 1, 3, 0};
    tbl[11] = '{7, 15, 0, 0, 0, 0, 0, 0, 0, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(cfg_in_ready), 64'(1));
    chk("rst_out_valid", 64'(cfg_out_valid), 64'(0));
    chk("rst_cfg_out", 64'(cfg_out), 64'(0));
    chk("rst_count", 64'(cfg_count), 64'(0));
    chk("rst_err_valid", 64'(err_valid), 64'(0));
    chk("rst_err_code", 64'(err_code), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single record: COMMIT bubble, then head visible two cycles after the last beat
    v = tbl[0];
    send_rec(v);
    chk("commit_ready_low", 64'(cfg_in_ready), 64'(0));
    chk("commit_valid_low", 64'(cfg_out_valid), 64'(0));
    @(negedge clk);
    chk("n2_valid", 64'(cfg_out_valid), 64'(1));
    chk("n2_count", 64'(cfg_count), 64'(1));
    chk("n2_data", 64'(cfg_out), 64'(pack(v)));
    chk("n2_no_err", 64'(err_valid), 64'(0));
    chk("n2_ready", 64'(cfg_in_ready), 64'(1));
    model_apply(v, 0);
    pop_one();

    // Table of records with hand-derived verdicts
    for (int i = 0; i < 12; i++) begin
      send_rec(tbl[i]);
      model_apply(tbl[i], tbl[i].code);
      check_state("tbl");
      if (tbl[i].code == 0) pop_one();
    end

    // Fill the FIFO, fifth record waits in COMMIT until the first pop
    for (int i = 0; i < 5; i++) begin
      v = '{i + 1, 2, 3, 10 * i, 20 * i, 0, 30 * i, 0, i, 0};
      if (i < 4) begin
        send_rec(v);
        model_apply(v, 0);
        check_state("fill");
      end else begin
        v5 = v;
        send_rec(v5);
        repeat (3) @(negedge clk);
        chk("full_stall_ready", 64'(cfg_in_ready), 64'(0));
        chk("full_stall_count", 64'(cfg_count), 64'(4));
      end
    end
    pop_one();
    m_q.push_back(pack(v5));
    chk("full_pop_push_count", 64'(cfg_count), 64'(4));
    chk("full_pop_push_ready", 64'(cfg_in_ready), 64'(1));
    while (m_q.size() > 0) pop_one();
    chk("full_drained", 64'(cfg_count), 64'(0));

    // Framing: early last, then overrun swallowed by DRAIN
    beat(16'h1234, 1'b0);
    beat(16'h5678, 1'b1);
    chk("early_last_pulse", 64'(err_valid), 64'(1));
    model_err(2'b01);
    check_state("early_last");
    v = '{3, 3, 3, 1, 2, 3, 4, 0, 6, 0};
    send_rec(v);
    model_apply(v, 0);
    check_state("after_frame");
    for (int k = 0; k < 5; k++) begin
      beat(16'(k + 16'hA0), k == 4);
      if (k == 3) chk("overrun_pulse", 64'(err_valid), 64'(1));
    end
    model_err(2'b01);
    check_state("drain");
    v = '{5, 6, 7, 8, 9, 10, 11, 1, 12, 0};
    send_rec(v);
    model_apply(v, 0);
    check_state("after_drain");
    while (m_q.size() > 0) pop_one();

    // Flush in the middle of a fourth record
    for (int i = 0; i < 3; i++) begin
      v = '{i + 2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      send_rec(v);
      model_apply(v, 0);
      check_state("preflush");
    end
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    flush = 1'b1;
    cfg_in_valid = 1'b1;
    cfg_in_data = 16'h3333;
    @(negedge clk);
    flush = 1'b0;
    cfg_in_valid = 1'b0;
    m_q.delete();
    chk("flush_count", 64'(cfg_count), 64'(0));
    chk("flush_valid", 64'(cfg_out_valid), 64'(0));
    chk("flush_ready", 64'(cfg_in_ready), 64'(1));
    chk("flush_no_err", 64'(err_valid), 64'(0));
    v = '{9, 8, 7, 6, 5, 4, 3, 1, 2, 0};
    send_rec(v);
    model_apply(v, 0);
    check_state("postflush");
    pop_one();

    // Randomized records against the model
    for (int i = 0; i < 60; i++) begin
      if (m_q.size() == 4) pop_one();
      v.wr  = int'($urandom_range(0, 15));
      v.wc  = int'($urandom_range(0, 15));
      v.ir  = int'($urandom_range(0, 40));
      v.acc = int'($urandom_range(0, 1));
      v.ex  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        v.wo = int'($urandom_range(0, 60));
        v.io = int'($urandom_range(0, 60));
        v.po = int'($urandom_range(0, 60));
        v.oo = int'($urandom_range(0, 60));
      end else begin
        v.wo = int'($urandom_range(0, 511));
        v.io = int'($urandom_range(0, 511));
        v.po = int'($urandom_range(0, 511));
        v.oo = int'($urandom_range(0, 511));
      end
      v.code = model_code(v);
      send_rec(v);
      model_apply(v, v.code);
      check_state("rand");
      if ($urandom_range(0, 1) == 1 && m_q.size() > 0) pop_one();
    end
    while (m_q.size() > 0) pop_one();

    // err_count saturation with back-to-back single-beat framing errors
    for (int i = 0; i < 260; i++) begin
      beat(16'h0000, 1'b1);
      model_err(2'b01);
    end
    check_state("saturate");

    // Asynchronous reset mid-record with two entries queued
    for (int i = 0; i < 2; i++) begin
      v = '{i + 1, 4, 4, 0, 0, 0, 0, 0, 1, 0};
      send_rec(v);
      model_apply(v, 0);
      check_state("prereset");
    end
    beat(16'hBEEF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(cfg_in_ready), 64'(1));
    chk("arst_out_valid", 64'(cfg_out_valid), 64'(0));
    chk("arst_cfg_out", 64'(cfg_out), 64'(0));
    chk("arst_count", 64'(cfg_count), 64'(0));
    chk("arst_err_valid", 64'(err_valid), 64'(0));
    chk("arst_err_code", 64'(err_code), 64'(0));
    chk("arst_err_count", 64'(err_count), 64'(0));
    m_q.delete();
    m_errs = 0;
    m_raw = 0;
    m_code = 2'b00;
    pulses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{12, 11, 10, 9, 8, 7, 6, 1, 5, 0};
    send_rec(v);
    model_apply(v, 0);
    check_state("postreset");
    pop_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_cfg_queue.md
# matmul_cfg_queue

Parametrised configuration front-end for the systolic matrix-multiply engine. Accepts matrix-job configuration records as a stream of narrow bus beats and reassembles them into the packed `data_config_struct` layout, sized by parameter. Validates each record against memory and array bounds and queues accepted records in a DEPTH-entry FIFO for the matmul controller. Lets software post several jobs back-to-back instead of one static configuration.

## Interface
Parameters:
- MAX_ROW, 16: max weight rows; field width RW = $clog2(MAX_ROW)
- MAX_COL, 16: max weight cols; CW = $clog2(MAX_COL)
- W_SIZE, 512: weight memory words; WW = $clog2(W_SIZE)
- I_SIZE, 512: input memory words; IW = $clog2(I_SIZE)
- O_SIZE, 512: output/psum memory words; OW = $clog2(O_SIZE)
- EXTRA_BITS, 4: extra config bits
- BUS_W, 16: input beat width
- DEPTH, 4: FIFO entries, power of two, ≥2
- Derived: CFG_W = RW+CW+IW+WW+IW+2·OW+1+EXTRA_BITS (58 at defaults); NBEATS = ceil(CFG_W/BUS_W) (4 at defaults)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO and assembler
- cfg_in_valid  in  1  beat valid
- cfg_in_ready  out  1  beat accepted when valid&ready
- cfg_in_data  in  BUS_W  beat payload
- cfg_in_last  in  1  marks final beat of record
- cfg_out_valid  out  1  FIFO head valid
- cfg_out_ready  in  1  consumer pops head when valid&ready
- cfg_out  out  CFG_W  head record, packed MSB→LSB: w_rows, w_cols, i_rows, w_offset, i_offset, psum_offset, o_offset_w, accum_en, extra_config
- cfg_count  out  $clog2(DEPTH)+1  FIFO occupancy
- err_valid  out  1  one-cycle pulse per rejected record
- err_code  out  2  01 framing, 10 zero dimension, 11 range; held until next error
- err_count  out  8  rejected records, saturates at 255

## Operation
- Beats assembled LSB-first: beat k fills bits [k·BUS_W +: BUS_W]; bits ≥ CFG_W of final beat ignored.
- FSM states: ASSEMBLE, COMMIT, DRAIN.
- ASSEMBLE: cfg_in_ready=1. Beat counter increments per accepted beat.
  - last on beat NBEATS-1 → COMMIT.
  - last on beat < NBEATS-1 → framing error, counter cleared, stay ASSEMBLE.
  - beat NBEATS-1 without last → framing error, → DRAIN.
- DRAIN: cfg_in_ready=1; discard beats until one with last accepted → ASSEMBLE, counter 0.
- COMMIT: cfg_in_ready=0. Checks, in priority:
  - zero dimension: w_rows, w_cols or i_rows == 0 → code 10.
  - range: w_offset+w_rows > W_SIZE, i_offset+i_rows > I_SIZE, o_offset_w+i_rows > O_SIZE, or accum_en and psum_offset+i_rows > O_SIZE → code 11. Sums computed one bit wider than operands, no wrap.
  - Rejected: err pulse, → ASSEMBLE.
  - Valid, FIFO not full, or full with pop this cycle: push, → ASSEMBLE.
  - Valid, full, no pop: stay COMMIT, retry each cycle.
- FIFO: circular, DEPTH entries, extra pointer bit distinguishes full/empty. cfg_out registered from head entry. Push and pop in same cycle: count unchanged. Pop when empty ignored.
- flush (priority over all else except reset): pointers, count and beat counter to 0, FSM → ASSEMBLE, in-flight beat and COMMIT record discarded. err_code and err_count unaffected, no err pulse.
- Reset mid-record: everything discarded.

## Timing
- Reset values: cfg_in_ready=1 (ASSEMBLE), cfg_out_valid=0, cfg_out=0, cfg_count=0, err_valid=0, err_code=00, err_count=0.
- Last beat accepted cycle N → COMMIT cycle N+1 → cfg_out_valid=1 and cfg_count incremented in N+2 (empty FIFO).
- Minimum record period NBEATS+1 cycles (one COMMIT bubble).
- err_valid pulses in cycle N+2 for check errors; framing errors pulse the cycle after the offending beat.
- err_count increments on each err_valid; saturates at 255.
- cfg_out_valid never depends combinationally on cfg_out_ready; cfg_in_ready is FSM-state only.

## Test plan
- Single record w_rows=4, w_cols=4, i_rows=8, w_offset=0, i_offset=16, psum_offset=0, o_offset_w=32, accum_en=0, extra=0, 4 beats, last on beat 3 -> cfg_out equals packed record 2 cycles after last beat, cfg_count=1, no error.
- Push 5 valid records with cfg_out_ready=0 (DEPTH=4) -> count saturates at 4, cfg_in_ready low in COMMIT for 5th; raise cfg_out_ready -> 5th pushed in the cycle of the first pop, order preserved.
- Last asserted on beat 1, then a good 4-beat record -> err_code=01, err_count=1, good record queued. Then 5 beats without last until beat 4 -> DRAIN swallows them, err_count=2.
- i_offset=500, i_rows=20 -> err_code=11, not queued. w_cols=0 -> err_code=10. accum_en=1, psum_offset=510, i_rows=4 -> code 11.
- Queue 3 records, assert flush mid-beat of 4th -> cfg_count=0, cfg_out_valid=0 next cycle, next full record queued normally.
- Assert rst_n low mid-record with 2 entries queued -> all outputs at reset values asynchronously, err_count=0.
